pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the fetch stage of the single-cycle CPU. It holds the architectural PC and selects the next PC from sequential, conditional-branch, jump, return and exception sources with fixed priority. It adds an execution gate with stall, a reset vector, and a small return-address stack (RAS) that flags mismatched returns. Outputs feed instruction memory and the branch-address adder.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 38 +++
 rtl/pc_sequencer_ras_stack.sv | 70 +++++++
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

    // Next-PC source, listed from lowest to highest priority.
    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JMP,
        SRC_RET,
        SRC_EXC
    } pc_src_e;

    // Pointer width for a return stack of the given depth (at least 1 bit).
    function automatic int unsigned ras_ptr_w(input int unsigned depth);
        for (int unsigned w = 1; w < 32; w++) begin
            if ((32'd1 << w) >= depth) return w;
        end
        return 32;
    endfunction

    // Mask that clears the low log2(inst_bytes) bits of an address.
    function automatic logic [63:0] align_mask(input int unsigned inst_bytes);
        return ~(64'(inst_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage control/target inputs and PC/RAS status outputs of the sequencer.
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            en;
    logic            stall;
    logic            branch;
    logic            zero;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            call;
    logic            ret;
    logic [XLEN-1:0] ret_target;
    logic            exc;
    logic [XLEN-1:0] exc_vector;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next_seq;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_overflow;
    logic            ret_mismatch;
    logic            misaligned;

    modport master (
        output en, stall, branch, zero, branch_target, jump, jump_target,
               call, ret, ret_target, exc, exc_vector,
        input  pc, pc_next_seq, ras_empty, ras_full, ras_overflow,
               ret_mismatch, misaligned
    );

    modport slave (
        input  en, stall, branch, zero, branch_target, jump, jump_target,
               call, ret, ret_target, exc, exc_vector,
        output pc, pc_next_seq, ras_empty, ras_full, ras_overflow,
               ret_mismatch, misaligned
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack with saturating count and sticky overflow.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full,
    output logic            o_overflow
);
    localparam int unsigned PW = ras_ptr_w(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_top;
    logic [CW-1:0]   r_count;
    logic            r_overflow;

    logic            w_replace;
    logic [PW-1:0]   w_wr_idx;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CW'(RAS_DEPTH));
    assign o_overflow = r_overflow;
    assign o_top      = r_mem[r_top];

    // Pop-then-push on a non-empty stack collapses to an in-place replace of the top.
    assign w_replace = i_push && i_pop && !o_empty;
    assign w_wr_idx  = w_replace ? r_top : r_top + PW'(1);

    // Entry storage; contents beyond the count are never observed, so no reset.
    always_ff @(posedge clock) begin
        if (i_push && !i_flush) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    // Pointer, count and sticky overflow; flush keeps the overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_top      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_replace) begin
            r_top   <= r_top;
            r_count <= r_count;
        end else if (i_push) begin
            r_top <= r_top + PW'(1);
            if (o_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_top   <= r_top - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register with prioritised next-PC select, RAS and status pulses.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     INST_BYTES   = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INST_BYTES));
    localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);

    logic [XLEN-1:0] r_pc;
    logic            r_ret_mismatch;
    logic            r_misaligned;

    logic            w_advance;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_mismatch;
    logic            w_tgt_misaligned;
    pc_src_e         w_src;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic            w_ras_overflow;

    assign w_advance = bus.en && (!bus.stall || bus.exc);
    assign w_flush   = w_advance && bus.exc;
    assign w_push    = w_advance && !bus.exc && bus.call;
    assign w_pop     = w_advance && !bus.exc && bus.ret;
    assign w_pc_seq  = r_pc + STEP;

    // Fixed-priority next-PC source and raw redirect target.
    always_comb begin
        w_src    = SRC_SEQ;
        w_target = '0;
        if (bus.exc) begin
            w_src    = SRC_EXC;
            w_target = bus.exc_vector;
        end else if (bus.ret) begin
            w_src    = SRC_RET;
            w_target = bus.ret_target;
        end else if (bus.jump) begin
            w_src    = SRC_JMP;
            w_target = bus.jump_target;
        end else if (bus.branch && bus.zero) begin
            w_src    = SRC_BR;
            w_target = bus.branch_target;
        end
    end

    assign w_tgt_misaligned = (w_src != SRC_SEQ) && ((w_target & ~ALIGN_MASK) != '0);
    assign w_pc_next        = (w_src == SRC_SEQ) ? w_pc_seq : (w_target & ALIGN_MASK);
    assign w_mismatch       = w_pop && (w_ras_empty || (w_ras_top != bus.ret_target));

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (w_flush),
        .i_data     (w_pc_seq),
        .o_top      (w_ras_top),
        .o_empty    (w_ras_empty),
        .o_full     (w_ras_full),
        .o_overflow (w_ras_overflow)
    );

    // PC update on advance; status pulses last exactly one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc           <= RESET_VECTOR;
            r_ret_mismatch <= 1'b0;
            r_misaligned   <= 1'b0;
        end else begin
            r_ret_mismatch <= w_mismatch;
            r_misaligned   <= w_advance && w_tgt_misaligned;
            if (w_advance) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign bus.pc           = r_pc;
    assign bus.pc_next_seq  = w_pc_seq;
    assign bus.ras_empty    = w_ras_empty;
    assign bus.ras_full     = w_ras_full;
    assign bus.ras_overflow = w_ras_overflow;
    assign bus.ret_mismatch = r_ret_mismatch;
    assign bus.misaligned   = r_misaligned;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based reference model.
module tb_pc_sequencer;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    bit   chk_en;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    bit          m_ovf;
    bit          m_mism;
    bit          m_mis;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(
        .XLEN         (32),
        .INST_BYTES   (4),
        .RESET_VECTOR (32'h0000_0000),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_ras.delete();
        m_ovf  = 1'b0;
        m_mism = 1'b0;
        m_mis  = 1'b0;
    endtask

    // Next state from the architectural rules, applied at the clock edge.
    task automatic model_step();
        logic [31:0] tgt;
        bit          redir;
        if (!rst_n) return;
        m_mism = 1'b0;
        m_mis  = 1'b0;
        if (!(bus.en && (!bus.stall || bus.exc))) return;
        redir = 1'b1;
        tgt   = 32'h0;
        if (bus.exc)                     tgt = bus.exc_vector;
        else if (bus.ret)                tgt = bus.ret_target;
        else if (bus.jump)               tgt = bus.jump_target;
        else if (bus.branch && bus.zero) tgt = bus.branch_target;
        else                             redir = 1'b0;
        if (bus.exc) begin
            m_ras.delete();
        end else begin
            if (bus.ret) begin
                if (m_ras.size() == 0) m_mism = 1'b1;
                else begin
                    m_mism = (m_ras[$] != bus.ret_target);
                    void'(m_ras.pop_back());
                end
            end
            if (bus.call) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
            end
        end
        m_mis = redir && (tgt % 4 != 0);
        m_pc  = redir ? (tgt / 4) * 4 : m_pc + 32'd4;
    endtask

    task automatic clr();
        bus.en = 1'b1; bus.stall = 1'b0; bus.branch = 1'b0; bus.zero = 1'b0;
        bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.exc = 1'b0;
        bus.branch_target = '0; bus.jump_target = '0;
        bus.ret_target = '0; bus.exc_vector = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_call(input logic [31:0] t);
        clr(); bus.call = 1'b1; bus.jump = 1'b1; bus.jump_target = t; step();
    endtask

    task automatic do_ret(input logic [31:0] t);
        clr(); bus.ret = 1'b1; bus.ret_target = t; step();
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", bus.pc, m_pc);
            chk("pc_next_seq", bus.pc_next_seq, m_pc + 32'd4);
            chk("ras_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
            chk("ras_full", 32'(bus.ras_full), 32'(m_ras.size() == DEPTH));
            chk("ras_overflow", 32'(bus.ras_overflow), 32'(m_ovf));
            chk("ret_mismatch", 32'(bus.ret_mismatch), 32'(m_mism));
            chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        chk_en  = 1'b0;
        rst_n   = 1'b0;
        clr();
        bus.en = 1'b0;
        model_reset();
        #1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_next_seq", bus.pc_next_seq, 32'h4);
        chk("rst_empty", 32'(bus.ras_empty), 32'd1);
        chk("rst_full", 32'(bus.ras_full), 32'd0);
        chk("rst_ovf", 32'(bus.ras_overflow), 32'd0);
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;

        clr(); step(); step(); step();
        chk("seq_pc", bus.pc, 32'hC);
        bus.stall = 1'b1; step(); step();
        chk("stall_pc", bus.pc, 32'hC);
        clr(); bus.en = 1'b0; bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_target = 32'h40; step();
        chk("en0_pc", bus.pc, 32'hC);

        clr(); bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_target = 32'h40; step();
        chk("br_taken", bus.pc, 32'h40);
        bus.zero = 1'b0; step();
        chk("br_not_taken", bus.pc, 32'h44);
        bus.zero = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h80; step();
        chk("jmp_over_br", bus.pc, 32'h80);

        do_call(32'h100); do_call(32'h200); do_call(32'h300); do_call(32'h400);
        chk("full_at_depth", 32'(bus.ras_full), 32'd1);
        chk("no_ovf_yet", 32'(bus.ras_overflow), 32'd0);
        do_call(32'h500);
        chk("ovf_set", 32'(bus.ras_overflow), 32'd1);
        do_ret(32'h404); chk("ret1_ok", 32'(bus.ret_mismatch), 32'd0);
        do_ret(32'h304); chk("ret2_ok", 32'(bus.ret_mismatch), 32'd0);
        do_ret(32'h204); chk("ret3_ok", 32'(bus.ret_mismatch), 32'd0);
        do_ret(32'h104); chk("ret4_ok", 32'(bus.ret_mismatch), 32'd0);
        do_ret(32'h84);
        chk("ret5_mism", 32'(bus.ret_mismatch), 32'd1);
        chk("ret5_pc", bus.pc, 32'h84);

        do_ret(32'h100);
        chk("empty_ret_pc", bus.pc, 32'h100);
        chk("empty_ret_mism", 32'(bus.ret_mismatch), 32'd1);
        chk("empty_ret_cnt", 32'(bus.ras_empty), 32'd1);
        clr(); step();
        chk("mism_pulse_end", 32'(bus.ret_mismatch), 32'd0);

        do_call(32'h300);
        clr(); bus.call = 1'b1; bus.ret = 1'b1; bus.ret_target = 32'h108;
        bus.jump = 1'b1; bus.jump_target = 32'h500; step();
        chk("cr_pc", bus.pc, 32'h108);
        chk("cr_mism", 32'(bus.ret_mismatch), 32'd0);
        chk("cr_not_empty", 32'(bus.ras_empty), 32'd0);
        do_ret(32'h304);
        chk("cr_top", 32'(bus.ret_mismatch), 32'd0);
        chk("cr_count1", 32'(bus.ras_empty), 32'd1);

        do_call(32'h200);
        clr(); bus.exc = 1'b1; bus.stall = 1'b1; bus.call = 1'b1; bus.exc_vector = 32'h80; step();
        chk("exc_pc", bus.pc, 32'h80);
        chk("exc_flush", 32'(bus.ras_empty), 32'd1);
        chk("exc_ovf_kept", 32'(bus.ras_overflow), 32'd1);
        clr(); bus.jump = 1'b1; bus.jump_target = 32'h42; step();
        chk("mis_pc", bus.pc, 32'h40);
        chk("mis_pulse", 32'(bus.misaligned), 32'd1);
        clr(); step();
        chk("mis_pulse_end", 32'(bus.misaligned), 32'd0);

        clr(); bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC; step();
        clr(); step();
        chk("wrap_pc", bus.pc, 32'h0);

        do_call(32'h300); do_call(32'h400); do_call(32'h1FC);
        clr(); step();
        chk("pre_rst_pc", bus.pc, 32'h200);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", bus.pc, 32'h0);
        chk("async_rst_empty", 32'(bus.ras_empty), 32'd1);
        step();
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_pc", bus.pc, 32'h8);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
